// File: rtl/img_pair_xform_engine.sv
// rtl/img_pair_xform_engine.sv - mirrored column-pair flip/invert engine for a packed-pixel image RAM
//
// Walks an IMG_W x IMG_H image held in a 2-read/2-write port memory. Each step
// reads one mirrored column pair (A, B) of a row and writes it back with an
// optional left-right swap and/or per-channel colour inversion. One pair takes
// 3 cycles (RD, WT, WR).
//
// Optional feature macro: XFORM_DST_BASE_EN
//   defined   -> extra input dst_base; writes go to dst_base+A / dst_base+B
//                (out-of-place transform, reads unchanged)
//   undefined -> in-place transform
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   start                        one-cycle run request, honoured only in IDLE
//   mode_hflip, mode_invert      run mode, sampled on an accepted start
//   dst_base                     write base address (XFORM_DST_BASE_EN only)
//   busy, done                   run in progress / level set at run end
//   mem_en_r1_n, mem_en_r2_n     active-low read enables
//   mem_addr_r1, mem_addr_r2     read addresses
//   mem_data_r1, mem_data_r2     read data, one-cycle latency
//   mem_en_w1_n, mem_en_w2_n     active-low write enables
//   mem_addr_w1, mem_addr_w2     write addresses
//   mem_data_w1, mem_data_w2     write data

module img_pair_xform_engine #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int CH     = 3,
  parameter int BPC    = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode_hflip,
  input  logic              mode_invert,
`ifdef XFORM_DST_BASE_EN
  input  logic [ADDR_W-1:0] dst_base,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_en_r1_n,
  output logic              mem_en_r2_n,
  output logic [ADDR_W-1:0] mem_addr_r1,
  output logic [ADDR_W-1:0] mem_addr_r2,
  input  logic [DATA_W-1:0] mem_data_r1,
  input  logic [DATA_W-1:0] mem_data_r2,
  output logic              mem_en_w1_n,
  output logic              mem_en_w2_n,
  output logic [ADDR_W-1:0] mem_addr_w1,
  output logic [ADDR_W-1:0] mem_addr_w2,
  output logic [DATA_W-1:0] mem_data_w1,
  output logic [DATA_W-1:0] mem_data_w2
);

  localparam int PIX_W = CH * BPC;
  localparam int HALF  = (IMG_W + 1) / 2;

  localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(HALF - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_STEP   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WT   = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t            state;
  logic              hflip_q;
  logic              invert_q;
  logic [ADDR_W-1:0] x_q;
  logic [ADDR_W-1:0] row_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] wbase_q;

  // Channel inversion (2^BPC-1)-c equals bitwise NOT within each channel, so
  // the whole pixel field is XORed; bits above CH*BPC are forced to zero.
  function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d,
                                              input logic inv);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < PIX_W; i++) r[i] = d[i] ^ inv;
    return r;
  endfunction

  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] next_x;
  logic [ADDR_W-1:0] next_row_base;
  logic [ADDR_W-1:0] next_a;
  logic [ADDR_W-1:0] next_b;
  logic              last_x;
  logic              last_pair;
  logic              middle;

  // Pair addresses come from a running row base; no multiplier.
  always_comb begin
    addr_a        = row_base_q + x_q;
    addr_b        = row_base_q + W_LAST - x_q;
    last_x        = (x_q == X_LAST);
    last_pair     = last_x && (row_q == ROW_LAST);
    next_x        = last_x ? '0 : x_q + ADDR_W'(1);
    next_row_base = last_x ? row_base_q + W_STEP : row_base_q;
    next_a        = next_row_base + next_x;
    next_b        = next_row_base + W_LAST - next_x;
    middle        = (addr_a == addr_b);
  end

  // Outputs are registered on the edge that enters a state, so read
  // addresses are on the bus during RD and data returns during WT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      hflip_q     <= 1'b0;
      invert_q    <= 1'b0;
      x_q         <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
      wbase_q     <= '0;
      mem_en_r1_n <= 1'b1;
      mem_en_r2_n <= 1'b1;
      mem_addr_r1 <= '0;
      mem_addr_r2 <= '0;
      mem_en_w1_n <= 1'b1;
      mem_en_w2_n <= 1'b1;
      mem_addr_w1 <= '0;
      mem_addr_w2 <= '0;
      mem_data_w1 <= '0;
      mem_data_w2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hflip_q     <= mode_hflip;
            invert_q    <= mode_invert;
`ifdef XFORM_DST_BASE_EN
            wbase_q     <= dst_base;
`else
            wbase_q     <= '0;
`endif
            done        <= 1'b0;
            busy        <= 1'b1;
            x_q         <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            mem_addr_r1 <= '0;
            mem_addr_r2 <= W_LAST;
            mem_en_r1_n <= 1'b0;
            mem_en_r2_n <= 1'b0;
            state       <= RD;
          end
        end
        RD: begin
          mem_en_r1_n <= 1'b1;
          mem_en_r2_n <= 1'b1;
          state       <= WT;
        end
        WT: begin
          // Read data is valid now; it goes straight into the write registers.
          mem_en_w1_n <= 1'b0;
          mem_en_w2_n <= middle;
          mem_addr_w1 <= wbase_q + addr_a;
          mem_addr_w2 <= wbase_q + addr_b;
          mem_data_w1 <= xform(hflip_q ? mem_data_r2 : mem_data_r1, invert_q);
          mem_data_w2 <= xform(hflip_q ? mem_data_r1 : mem_data_r2, invert_q);
          state       <= WR;
        end
        WR: begin
          mem_en_w1_n <= 1'b1;
          mem_en_w2_n <= 1'b1;
          x_q         <= next_x;
          row_base_q  <= next_row_base;
          if (last_x) row_q <= row_q + ADDR_W'(1);
          if (last_pair) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            mem_addr_r1 <= next_a;
            mem_addr_r2 <= next_b;
            mem_en_r1_n <= 1'b0;
            mem_en_r2_n <= 1'b0;
            state       <= RD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img_pair_xform_engine.sv
// tb/tb_img_pair_xform_engine.sv - scoreboard bench for img_pair_xform_engine

module tb_img_pair_xform_engine;

  localparam int W     = 5;
  localparam int H     = 3;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int MEM   = 1 << AW;
  localparam int HALF  = (W + 1) / 2;
  localparam int PAIRS = H * HALF;
  localparam int LIMIT = 1000;

  typedef struct packed {
    logic [1:0]    port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mode_hflip = 1'b0;
  logic          mode_invert = 1'b0;
  logic [AW-1:0] dst_base = '0;
  logic          busy, done;
  logic          en_r1_n, en_r2_n, en_w1_n, en_w2_n;
  logic [AW-1:0] addr_r1, addr_r2, addr_w1, addr_w2;
  logic [DW-1:0] data_r1, data_r2, data_w1, data_w2;

  logic [DW-1:0] mem     [0:MEM-1];
  logic [DW-1:0] cur_img [0:MEM-1];
  logic [DW-1:0] src     [0:MEM-1];
  logic          load_req = 1'b0;

  wr_t exp_q[$];
  wr_t obs_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  img_pair_xform_engine #(
    .IMG_W(W), .IMG_H(H), .CH(3), .BPC(8), .DATA_W(DW), .ADDR_W(AW)
  ) u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .mode_hflip(mode_hflip),
    .mode_invert(mode_invert),
`ifdef XFORM_DST_BASE_EN
    .dst_base(dst_base),
`endif
    .busy(busy),
    .done(done),
    .mem_en_r1_n(en_r1_n),
    .mem_en_r2_n(en_r2_n),
    .mem_addr_r1(addr_r1),
    .mem_addr_r2(addr_r2),
    .mem_data_r1(data_r1),
    .mem_data_r2(data_r2),
    .mem_en_w1_n(en_w1_n),
    .mem_en_w2_n(en_w2_n),
    .mem_addr_w1(addr_w1),
    .mem_addr_w2(addr_w2),
    .mem_data_w1(data_w1),
    .mem_data_w2(data_w2)
  );

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < MEM; i++) mem[i] <= cur_img[i];
    end else begin
      if (!en_w1_n) mem[addr_w1] <= data_w1;
      if (!en_w2_n) mem[addr_w2] <= data_w2;
    end
    if (!en_r1_n) data_r1 <= mem[addr_r1];
    if (!en_r2_n) data_r2 <= mem[addr_r2];
  end

  always @(negedge clk) begin
    if (reset_n && !en_w1_n) obs_q.push_back({2'd1, addr_w1, data_w1});
    if (reset_n && !en_w2_n) obs_q.push_back({2'd2, addr_w2, data_w2});
  end

  function automatic logic [DW-1:0] fx(input logic [DW-1:0] d, input bit inv);
    return inv ? (~d & 32'h00FF_FFFF) : (d & 32'h00FF_FFFF);
  endfunction

  function automatic void plan_run(input bit hf, input bit inv, input logic [AW-1:0] db);
    int a, b;
    logic [DW-1:0] da, dbv, w1, w2;
    for (int r = 0; r < H; r++) begin
      for (int x = 0; x < HALF; x++) begin
        a = r * W + x;
        b = r * W + W - 1 - x;
        da  = cur_img[a];
        dbv = cur_img[b];
        w1 = fx(hf ? dbv : da, inv);
        w2 = fx(hf ? da : dbv, inv);
        exp_q.push_back({2'd1, AW'(db + a), w1});
        cur_img[AW'(db + a)] = w1;
        if (a != b) begin
          exp_q.push_back({2'd2, AW'(db + b), w2});
          cur_img[AW'(db + b)] = w2;
        end
      end
    end
  endfunction

  task automatic fill_random();
    for (int i = 0; i < MEM; i++) cur_img[i] = $urandom;
  endtask

  task automatic load_mem();
    for (int i = 0; i < MEM; i++) src[i] = cur_img[i];
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic launch(input bit hf, input bit inv, input logic [AW-1:0] db);
    @(negedge clk);
    start = 1'b1; mode_hflip = hf; mode_invert = inv; dst_base = db;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
    n_tests++;
    if ({en_r1_n, en_r2_n, en_w1_n, en_w2_n} !== 4'b1111) begin
      n_fail++; $display("FAIL reset_enables got %b want 1111", {en_r1_n, en_r2_n, en_w1_n, en_w2_n});
    end
    n_tests++;
    if ({addr_r1, addr_r2, addr_w1, addr_w2, data_w1, data_w2} !== '0) begin
      n_fail++; $display("FAIL reset_addr_data got %h %h %h %h %h %h want 0", addr_r1, addr_r2, addr_w1, addr_w2, data_w1, data_w2);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_hflip();
    int cyc, bad;
    wr_t e, o;
    for (int i = 0; i < MEM; i++) cur_img[i] = 32'(i + 1);
    load_mem();
    plan_run(1'b1, 1'b0, '0);
    launch(1'b1, 1'b0, '0);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL hflip_busy_after_start got %b want 1", busy); end
    wait_done(0, cyc);
    n_tests++;
    if (cyc != 3 * PAIRS) begin n_fail++; $display("FAIL hflip_cycles got %0d want %0d", cyc, 3 * PAIRS); end
    n_tests++;
    if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL hflip_end_flags got %b want 01", {busy, done}); end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL hflip_sb_missing want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL hflip_sb got %h want %h", o, e); end
      end
    end
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL hflip_sb_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    n_tests++;
    if (mem[0] !== 32'd5 || mem[1] !== 32'd4 || mem[2] !== 32'd3 || mem[4] !== 32'd1) begin
      n_fail++; $display("FAIL hflip_row0 got %h %h %h %h want 5 4 3 1", mem[0], mem[1], mem[2], mem[4]);
    end
    bad = 0;
    for (int i = 0; i < MEM; i++) if (mem[i] !== cur_img[i]) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL hflip_image got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_modes();
    int cyc, bad, mid_w2;
    wr_t e, o;
    bit hf, inv;
    for (int m = 3; m >= 0; m--) begin
      if (m == 1) continue;
      hf  = m[0];
      inv = m[1];
      fill_random();
      if (m == 3) begin
        cur_img[0] = 32'h0000_0000; cur_img[1] = 32'h0010_2030; cur_img[2] = 32'hFFFF_FFFF;
        cur_img[3] = 32'h0010_2030; cur_img[4] = 32'h0000_0000;
      end
      load_mem();
      plan_run(hf, inv, '0);
      launch(hf, inv, '0);
      wait_done(0, cyc);
      n_tests++;
      if (cyc != 3 * PAIRS) begin n_fail++; $display("FAIL mode%0d_cycles got %0d want %0d", m, cyc, 3 * PAIRS); end
      @(negedge clk);
      mid_w2 = 0;
      foreach (obs_q[i]) if (obs_q[i].port == 2'd2 && (int'(obs_q[i].addr) % W) == HALF - 1) mid_w2++;
      n_tests++;
      if (mid_w2 != 0) begin n_fail++; $display("FAIL mode%0d_middle_w2 got %0d writes want 0", m, mid_w2); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (obs_q.size() == 0) begin n_fail++; $display("FAIL mode%0d_sb_missing want %h", m, e); end
        else begin
          o = obs_q.pop_front();
          if (o !== e) begin n_fail++; $display("FAIL mode%0d_sb got %h want %h", m, o, e); end
        end
      end
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL mode%0d_sb_extra got %0d want 0", m, obs_q.size()); obs_q.delete(); end
      if (m == 3) begin
        n_tests++;
        if (mem[0] !== 32'hFFFFFF || mem[1] !== 32'hEFDFCF || mem[2] !== 32'h0 || mem[3] !== 32'hEFDFCF || mem[4] !== 32'hFFFFFF) begin
          n_fail++; $display("FAIL mode3_row0 got %h %h %h %h %h want ffffff efdfcf 0 efdfcf ffffff", mem[0], mem[1], mem[2], mem[3], mem[4]);
        end
      end
      if (m == 2) begin
        n_tests++;
        if (mem[7] !== (src[7] ^ 32'h00FF_FFFF) - (src[7] & 32'hFF00_0000)) begin
          n_fail++; $display("FAIL mode2_pixel7 got %h want %h", mem[7], (src[7] ^ 32'h00FF_FFFF) & 32'h00FF_FFFF);
        end
      end
      bad = 0;
      for (int i = 0; i < MEM; i++) if (mem[i] !== cur_img[i]) bad++;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL mode%0d_image got %0d bad pixels want 0", m, bad); end
    end
  endtask

  task automatic test_start_ignored();
    int cyc, bad;
    wr_t e, o;
    fill_random();
    load_mem();
    plan_run(1'b1, 1'b0, '0);
    launch(1'b1, 1'b0, '0);
    repeat (4) @(negedge clk);
    start = 1'b1; mode_hflip = 1'b0; mode_invert = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, cyc);
    n_tests++;
    if (cyc != 3 * PAIRS) begin n_fail++; $display("FAIL ignored_cycles got %0d want %0d", cyc, 3 * PAIRS); end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL ignored_sb_missing want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL ignored_sb got %h want %h", o, e); end
      end
    end
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL ignored_sb_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    bad = 0;
    for (int i = 0; i < MEM; i++) if (mem[i] !== cur_img[i]) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL ignored_image got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_before got %b want 1", done); end
    plan_run(1'b0, 1'b0, '0);
    launch(1'b0, 1'b0, '0);
    n_tests++;
    if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL b2b_flags_after_start got %b want 10", {busy, done}); end
    wait_done(0, cyc);
    n_tests++;
    if (cyc != 3 * PAIRS) begin n_fail++; $display("FAIL b2b_cycles got %0d want %0d", cyc, 3 * PAIRS); end
    @(negedge clk);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_write_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midrun();
    int cyc, bad;
    wr_t e, o;
    fill_random();
    load_mem();
    launch(1'b1, 1'b1, '0);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, en_r1_n, en_r2_n, en_w1_n, en_w2_n} !== 6'b001111) begin
      n_fail++; $display("FAIL midreset_outputs got %b want 001111", {busy, done, en_r1_n, en_r2_n, en_w1_n, en_w2_n});
    end
    @(negedge clk);
    reset_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    fill_random();
    load_mem();
    plan_run(1'b0, 1'b1, '0);
    launch(1'b0, 1'b1, '0);
    wait_done(0, cyc);
    n_tests++;
    if (cyc != 3 * PAIRS) begin n_fail++; $display("FAIL midreset_cycles got %0d want %0d", cyc, 3 * PAIRS); end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL midreset_sb_missing want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL midreset_sb got %h want %h", o, e); end
      end
    end
    obs_q.delete();
    bad = 0;
    for (int i = 0; i < MEM; i++) if (mem[i] !== cur_img[i]) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL midreset_image got %0d bad pixels want 0", bad); end
  endtask

`ifdef XFORM_DST_BASE_EN
  task automatic test_dst_base();
    int cyc, bad;
    fill_random();
    load_mem();
    plan_run(1'b1, 1'b0, 12'h100);
    launch(1'b1, 1'b0, 12'h100);
    wait_done(0, cyc);
    @(negedge clk);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL dst_write_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    obs_q.delete();
    exp_q.delete();
    n_tests++;
    if (mem[12'h100] !== (src[4] & 32'h00FF_FFFF) || mem[12'h104] !== (src[0] & 32'h00FF_FFFF)) begin
      n_fail++; $display("FAIL dst_row0 got %h %h want %h %h", mem[12'h100], mem[12'h104], src[4] & 32'h00FF_FFFF, src[0] & 32'h00FF_FFFF);
    end
    bad = 0;
    for (int i = 0; i < W * H; i++) if (mem[i] !== src[i]) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL dst_source_changed got %0d changed want 0", bad); end
    bad = 0;
    for (int i = 0; i < MEM; i++) if (mem[i] !== cur_img[i]) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL dst_image got %0d bad pixels want 0", bad); end
  endtask
`endif

  initial begin
    test_reset();
    test_hflip();
    test_modes();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
`ifdef XFORM_DST_BASE_EN
    test_dst_base();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/img_pair_xform_engine.md
Name: img_pair_xform_engine

Overview:
- Parametrised successor to the flip/invert image engine.
- Walks an IMG_W x IMG_H packed-pixel image held in an external 2-read/2-write port memory, one mirrored column pair per step.
- Per run, selectable horizontal flip and/or colour inversion over CH channels of BPC bits each.
- Sits beside the image RAM; started by a pulse from the testbench or host FSM; reports busy/done.

Parameters:
- IMG_W, 320, image width in pixels (>=1)
- IMG_H, 240, image height in pixels (>=1)
- CH, 3, colour channels per pixel
- BPC, 8, bits per channel; CH*BPC <= DATA_W
- DATA_W, 32, memory word width; one pixel per word, channels packed from bit 0 (channel 0 = bits BPC-1:0)
- ADDR_W, 17, memory address width; IMG_W*IMG_H <= 2^ADDR_W

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request; honoured only in IDLE
- mode_hflip  in  1  1 = mirror each row left-right; sampled on accepted start
- mode_invert  in  1  1 = replace each channel c by (2^BPC-1)-c; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until the run ends
- done  out  1  level; set at run end, cleared by the next accepted start or by reset
- mem_en_r1_n, mem_en_r2_n  out  1  active-low read enables
- mem_addr_r1, mem_addr_r2  out  ADDR_W  read addresses
- mem_data_r1, mem_data_r2  in  DATA_W  read data, one-cycle latency
- mem_en_w1_n, mem_en_w2_n  out  1  active-low write enables
- mem_addr_w1, mem_addr_w2  out  ADDR_W  write addresses
- mem_data_w1, mem_data_w2  out  DATA_W  write data

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, all en_*_n=1, all addresses 0, all write data 0, state=IDLE, counters 0.
- Pair walk, for each row r in 0..IMG_H-1 and each x in 0..ceil(IMG_W/2)-1:
  - A = r*IMG_W + x, B = r*IMG_W + (IMG_W-1-x).
  - Row base is kept as a running sum (+IMG_W per row); no multiplier.
- FSM states IDLE, RD, WT, WR:
  - IDLE: on start, latch the mode bits, clear done, set busy, load counters, go to RD.
  - RD: drive mem_addr_r1=A, mem_addr_r2=B, both read enables low; go to WT.
  - WT: read enables high; capture dA=mem_data_r1 and dB=mem_data_r2 at the end of WT; go to WR.
  - WR: drive the writes below, then advance x/row.
    - More pairs remain: go to RD.
    - Last pair: go to IDLE with busy=0 and done=1 on the same edge.
- Write data, with f = per-channel inversion when mode_invert, else identity:
  - mem_addr_w1=A, mem_data_w1 = f(mode_hflip ? dB : dA).
  - mem_addr_w2=B, mem_data_w2 = f(mode_hflip ? dA : dB).
- Bits DATA_W-1:CH*BPC of write data are driven 0.
- Timing: 3 cycles per pair; run length = 3*IMG_H*ceil(IMG_W/2) cycles from the first RD to done.
- Odd IMG_W, middle column (A==B): only port 1 writes; mem_en_w2_n stays 1, so no same-address dual write.
- IMG_W=1: every pair is a middle column.
- start while busy: ignored, and the mode is not re-sampled.
- start coincident with the final WR edge: ignored.
- Mode 00: a valid run; the image is rewritten unchanged.
- Reset mid-run: immediate return to reset values. Pixels already written stay modified; there is no rollback.

Optional Feature:
- Macro XFORM_DST_BASE_EN.
- Defined:
  - Adds input dst_base [ADDR_W-1:0], sampled on accepted start.
  - Write addresses become dst_base+A and dst_base+B (modulo 2^ADDR_W); read addresses are unchanged, giving an out-of-place transform.
  - The middle-column rule still applies.
- Undefined: no extra port; the transform is in-place, exactly as above.

Test Plan:
- IMG_W=4, IMG_H=2, mode 01 (hflip only), row0 = 0x000001..0x000004 -> row0 reads 4,3,2,1; done rises 12 cycles after the first RD; busy low with done high.
- IMG_W=3, IMG_H=1, mode 11, pixels 0x000000, 0x102030, 0xFFFFFF -> 0x000000, 0xEFDFCF, 0xFFFFFF; mem_en_w2_n never low on the middle pair.
- Default 320x240, mode 10 (invert only), random image -> every pixel = 0xFFFFFF XOR original; bits 31:24 are 0; done after 115200 cycles.
- Mid-run, assert reset_n low for 1 cycle, then start -> done=0 and enables =1 during reset; the second run completes normally; done clears on the new start.
- Pulse start again 5 cycles into a run with different mode bits -> ignored; result and cycle count match a single run with the original mode.
- With XFORM_DST_BASE_EN, dst_base=0x100, 4x1 image, mode 01 -> addresses 0x100..0x103 hold the mirrored row; source 0..3 unchanged.
